// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: 2-flop sync, stable counter, press/release pulses.
// Optional macro SW_DEBOUNCE_TOGGLE_EN makes SW_LEVEL a press-on/press-off latch.
module sw_debounce #(
  parameter int N_CH      = 6,
  parameter int DB_CYCLES = 250000
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] SW_RAW,
  output logic [N_CH-1:0] SW_LEVEL,
  output logic [N_CH-1:0] SW_PRESS,
  output logic [N_CH-1:0] SW_RELEASE
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  // Bring the asynchronous raw levels into the CLK domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW_RAW;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          stab;
    logic          prs;
    logic          rls;
    logic          differ;
    logic          done;

    assign differ = sync2[g] ^ stab;
    assign done   = differ && (cnt == CNT_MAX);

    // Count consecutive samples that disagree with the accepted level.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt <= '0;
      end else if (!differ || done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    // Accept the new level and emit a one-cycle edge pulse with it.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        stab <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
      end else begin
        prs <= done & sync2[g];
        rls <= done & ~sync2[g];
        if (done) begin
          stab <= sync2[g];
        end
      end
    end

    assign SW_PRESS[g]   = prs;
    assign SW_RELEASE[g] = rls;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic tog;

    // Flip the latched operand bit on the cycle after each press pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        tog <= 1'b0;
      end else begin
        tog <= tog ^ prs;
      end
    end

    assign SW_LEVEL[g] = tog;
`else
    assign SW_LEVEL[g] = stab;
`endif
  end

endmodule
